// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned MEM_CTRL_W           = 2;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    localparam logic [MEM_CTRL_W-1:0] MEM_NOP = 2'b00;
    localparam logic [MEM_CTRL_W-1:0] MEM_RD  = 2'b01;
    localparam logic [MEM_CTRL_W-1:0] MEM_WR  = 2'b10;

    // ARB: DMA may be granted; ACK: DMA completion cycle, CPU only
    typedef enum logic {
        ARB = 1'b0,
        ACK = 1'b1
    } arb_state_e;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive ARB cycles a pending DMA request loses to the CPU and
// flags a forced DMA slot once the limit is reached.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_phase,
    input  logic dma_req,
    input  logic dma_grant,
    output logic force_c
);

    logic [CNT_W-1:0] cnt_q;

    // Saturating loss counter; only moves in ARB, holds through ACK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (arb_phase) begin
            if (dma_grant || !dma_req) begin
                cnt_q <= '0;
            end else if (cnt_q < CNT_W'(STARVE_LIMIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Pending DMA has lost STARVE_LIMIT times in a row
    always_comb begin
        force_c = dma_req && (cnt_q == CNT_W'(STARVE_LIMIT));
    end

endmodule : dmem_arb_starve_ctr

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: MEM stage (primary) vs DMA/debug loader.
// Build option DMEM_ARB_FAIRNESS_EN adds a starvation counter that forces a
// DMA slot (stalling the CPU) after STARVE_LIMIT consecutive losses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  cpu_ctrl,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [1:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       force_c;
    logic       cpu_active_c;
    logic       dma_grant_c;
    logic       cpu_grant_c;

    assign cpu_active_c = (cpu_ctrl != MEM_NOP);
    assign cpu_rdata    = mem_rdata;

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .arb_phase (state_q == ARB),
        .dma_req   (dma_req),
        .dma_grant (dma_grant_c),
        .force_c   (force_c)
    );
`else
    logic [CNT_W-1:0] unused_limit;
    assign unused_limit = CNT_W'(STARVE_LIMIT);
    assign force_c      = 1'b0;
`endif

    // State register and registered DMA completion outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            state_q <= state_d;
            dma_ack <= dma_grant_c;
            if (dma_grant_c && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

    // Grant decision, next state and memory-port mux
    always_comb begin
        state_d     = state_q;
        dma_grant_c = 1'b0;
        cpu_grant_c = 1'b0;
        cpu_stall   = 1'b0;
        mem_ctrl    = MEM_NOP;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;

        case (state_q)
            ARB: begin
                if (force_c) begin
                    dma_grant_c = 1'b1;
                end else if (cpu_active_c) begin
                    cpu_grant_c = 1'b1;
                end else if (dma_req) begin
                    dma_grant_c = 1'b1;
                end
            end
            ACK: begin
                state_d     = ARB;
                cpu_grant_c = cpu_active_c;
            end
            default: state_d = ARB;
        endcase

        if (dma_grant_c) begin
            state_d   = ACK;
            mem_ctrl  = dma_we ? MEM_WR : MEM_RD;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
`ifdef DMEM_ARB_FAIRNESS_EN
            cpu_stall = cpu_active_c;
`endif
        end else if (cpu_grant_c) begin
            mem_ctrl = cpu_ctrl;
        end
    end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural arbitration model.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cpu_ctrl;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic [1:0]  mem_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_in_ack;
    int          m_lost;
    bit          m_ack;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [256];

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_ctrl  (cpu_ctrl),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_ctrl  (mem_ctrl),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 'h40) return 32'h1234_5678;
        if (i == 'h20) return 32'hCAFE_F00D;
        return {8'(i), 8'(~i), 8'(i * 3), 8'hA5};
    endfunction

    // Data memory: combinational read, posedge write, preloaded while in reset
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_ctrl[1]) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_ack = 1'b0;
        m_lost   = 0;
        m_ack    = 1'b0;
        m_rdata  = '0;
    endtask

    // One clock cycle: check outputs against the model at negedge, advance model at posedge
    task automatic cycle();
        bit          cpu_act, g_dma, g_cpu;
        logic [1:0]  e_ctrl;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        cpu_act = (cpu_ctrl != 2'b00);
        g_dma   = !m_in_ack && dma_req && ((FAIR && m_lost >= int'(LIMIT)) || !cpu_act);
        g_cpu   = !g_dma && cpu_act;
        if (g_dma) begin
            e_ctrl  = dma_we ? 2'b10 : 2'b01;
            e_addr  = dma_addr;
            e_wdata = dma_wdata;
        end else begin
            e_ctrl  = g_cpu ? cpu_ctrl : 2'b00;
            e_addr  = cpu_addr;
            e_wdata = cpu_wdata;
        end
        chk("mem_ctrl", 32'(mem_ctrl), 32'(e_ctrl));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_stall", 32'(cpu_stall), 32'(FAIR && g_dma && cpu_act));
        chk("dma_ack", 32'(dma_ack), 32'(m_ack));
        chk("dma_rdata", dma_rdata, m_rdata);
        if (g_cpu && cpu_ctrl == 2'b01) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
        @(posedge clk);
        if (g_dma) begin
            if (dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
            else        m_rdata = ref_mem[dma_addr[9:2]];
            m_lost = 0;
        end else if (!m_in_ack) begin
            m_lost = dma_req ? ((m_lost < int'(LIMIT)) ? m_lost + 1 : m_lost) : 0;
        end
        if (g_cpu && cpu_ctrl[1]) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        m_ack    = g_dma;
        m_in_ack = g_dma;
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        cpu_ctrl  = 2'b00;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset_n = 1'b1;

        // CPU read, zero latency
        cpu_ctrl = 2'b01; cpu_addr = 32'h100;
        #2;
        chk("cpu_rd_ctrl", 32'(mem_ctrl), 32'h1);
        chk("cpu_rd_addr", mem_addr, 32'h100);
        chk("cpu_rd_data", cpu_rdata, 32'h1234_5678);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        cycle();

        // DMA write while CPU idle
        cpu_ctrl = 2'b00;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
        #2;
        chk("dma_wr_ctrl", 32'(mem_ctrl), 32'h2);
        chk("dma_wr_addr", mem_addr, 32'h40);
        chk("dma_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        cycle();
        dma_req = 1'b0;
        #2;
        chk("dma_wr_ack", 32'(dma_ack), 32'd1);
        cycle();
        cpu_ctrl = 2'b01; cpu_addr = 32'h40;
        #2;
        chk("cpu_rd_after_dma", cpu_rdata, 32'hDEAD_BEEF);
        cycle();

        // CPU reading every cycle with a held DMA read of 0x80
        cpu_addr = 32'h200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
`ifdef DMEM_ARB_FAIRNESS_EN
        repeat (LIMIT) cycle();
        #2;
        chk("starve_stall", 32'(cpu_stall), 32'd1);
        chk("starve_addr", mem_addr, 32'h80);
        cycle();
        dma_req = 1'b0;
        #2;
        chk("starve_ack", 32'(dma_ack), 32'd1);
        chk("starve_rdata", dma_rdata, 32'hCAFE_F00D);
        chk("starve_ack_stall", 32'(cpu_stall), 32'd0);
        cycle();
        dma_req = 1'b1;
        repeat (LIMIT + 2) cycle();
`else
        repeat (8) cycle();
        cpu_ctrl = 2'b00;
        #2;
        chk("idle_grant_ctrl", 32'(mem_ctrl), 32'h1);
        chk("idle_grant_addr", mem_addr, 32'h80);
        cycle();
        dma_req = 1'b0;
        #2;
        chk("idle_grant_ack", 32'(dma_ack), 32'd1);
        chk("idle_grant_rdata", dma_rdata, 32'hCAFE_F00D);
        cycle();
`endif
        dma_req = 1'b0;
        cpu_ctrl = 2'b00;
        cycle();

        // Reset pulse during the ACK cycle
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100;
        cycle();
        dma_req = 1'b0;
        chk("pre_rst_ack", 32'(dma_ack), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_ack", 32'(dma_ack), 32'd0);
        chk("async_rst_rdata", dma_rdata, 32'd0);
        reset_n = 1'b1;
        model_reset();
        cpu_ctrl = 2'b01; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
        repeat (LIMIT + 3) cycle();
        dma_req = 1'b0;
        cpu_ctrl = 2'b00;
        cycle();

        // Randomised traffic; DMA driver keeps payload stable until its ack
        for (int n = 0; n < 600; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            cpu_ctrl  = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            cpu_wdata = $urandom;
            if (m_ack || !dma_req) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_we    = $urandom_range(0, 1) != 0;
                dma_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dma_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                dma_req = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
